// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: state encoding,
// stall vector bit indices, stall masks and default timing.
package mem_port_arbiter_pkg;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;
    localparam int STALL_W   = STALL_WB + 1;

    localparam int WAIT_CYCLES_DEF = 2;
    localparam int CNT_W_DEF       = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEM_ACC = 2'd1,
        ST_IF_ACC  = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

    // Mask freezing every stage from the PC up to and including 'top'.
    function automatic logic [STALL_W-1:0] stall_upto(input int top);
        logic [STALL_W-1:0] m;
        m = '0;
        for (int i = 0; i < STALL_W; i++) begin
            if (i <= top) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [STALL_W-1:0] STALL_MASK_MEM = stall_upto(STALL_MEM);
    localparam logic [STALL_W-1:0] STALL_MASK_ID  = stall_upto(STALL_ID);
    localparam logic [STALL_W-1:0] STALL_MASK_IF  = stall_upto(STALL_IF);

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Wait-state counter: start loads 0 and runs, clear stops it.
// Ports: start, clear, last (terminal count), done (count == last).
module wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic [CNT_W-1:0] last,
    output logic             done
);

    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign done = run_q && (cnt_q == last);

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        if (clear) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
        end else if (run_q) begin
            if (done) begin
                run_d = 1'b0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single SRAM port between IF and MEM (MEM first),
// runs fixed wait states, registers acks/rdata, drives stall_o.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    output logic [31:0]        if_rdata,
    output logic               if_ack,
    input  logic               mem_req,
    input  logic               mem_we,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    output logic [31:0]        mem_rdata,
    output logic               mem_ack,
    input  logic               flush_i,
    input  logic               stallreq_id,
    output logic [STALL_W-1:0] stall_o,
    output logic               bus_ce,
    output logic               bus_we,
    output logic [31:0]        bus_addr,
    output logic [31:0]        bus_wdata,
    input  logic [31:0]        bus_rdata
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    arb_state_e  state_q, state_d;
    logic        bus_ce_q, bus_ce_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        mem_ack_q, mem_ack_d;
    logic        cnt_start, cnt_clear, cnt_done;

    wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait (
        .clk   (clk),
        .rst   (rst),
        .start (cnt_start),
        .clear (cnt_clear),
        .last  (LAST),
        .done  (cnt_done)
    );

    always_comb begin
        state_d     = state_q;
        bus_ce_d    = bus_ce_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        cnt_start   = 1'b0;
        cnt_clear   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    state_d     = ST_MEM_ACC;
                    bus_ce_d    = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    cnt_start   = 1'b1;
                end else if (if_req && !flush_i) begin
                    state_d    = ST_IF_ACC;
                    bus_ce_d   = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = if_addr;
                    cnt_start  = 1'b1;
                end
            end
            ST_MEM_ACC: begin
                if (cnt_done) begin
                    state_d   = ST_RESP;
                    bus_ce_d  = 1'b0;
                    bus_we_d  = 1'b0;
                    mem_ack_d = 1'b1;
                    if (!bus_we_q) mem_rdata_d = bus_rdata;
                end
            end
            ST_IF_ACC: begin
                // A redirect wins over a fetch finishing on this edge.
                if (flush_i) begin
                    state_d   = ST_IDLE;
                    bus_ce_d  = 1'b0;
                    cnt_clear = 1'b1;
                end else if (cnt_done) begin
                    state_d    = ST_RESP;
                    bus_ce_d   = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = bus_rdata;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bus_ce_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_ce_q    <= bus_ce_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
        end
    end

    // Ack cycle drops the requester's own term so the pipeline advances.
    always_comb begin
        stall_o = '0;
        if (mem_req && !mem_ack_q) stall_o = stall_o | STALL_MASK_MEM;
        if (stallreq_id)           stall_o = stall_o | STALL_MASK_ID;
        if (if_req && !if_ack_q && !flush_i)
            stall_o = stall_o | STALL_MASK_IF;
    end

    assign bus_ce    = bus_ce_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stall table under reset,
// then hand sequences on a WAIT_CYCLES=2 and a WAIT_CYCLES=1 instance.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we, flush_i, stallreq_id;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;

    logic [31:0] a_if_rdata, a_mem_rdata, a_bus_addr, a_bus_wdata;
    logic        a_if_ack, a_mem_ack, a_bus_ce, a_bus_we;
    logic [5:0]  a_stall;

    logic [31:0] b_if_rdata, b_mem_rdata, b_bus_addr, b_bus_wdata;
    logic        b_if_ack, b_mem_ack, b_bus_ce, b_bus_we;
    logic [5:0]  b_stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WAIT_CYCLES(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(a_if_rdata), .if_ack(a_if_ack),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack),
        .flush_i(flush_i), .stallreq_id(stallreq_id),
        .stall_o(a_stall),
        .bus_ce(a_bus_ce), .bus_we(a_bus_we),
        .bus_addr(a_bus_addr), .bus_wdata(a_bus_wdata),
        .bus_rdata(bus_rdata)
    );

    mem_port_arbiter #(.WAIT_CYCLES(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(b_if_rdata), .if_ack(b_if_ack),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
        .flush_i(flush_i), .stallreq_id(stallreq_id),
        .stall_o(b_stall),
        .bus_ce(b_bus_ce), .bus_we(b_bus_we),
        .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata),
        .bus_rdata(bus_rdata)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    typedef struct {
        logic       mreq;
        logic       ireq;
        logic       fl;
        logic       sid;
        logic [5:0] stall;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b011111};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b000111};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000011};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b000000};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'b000111};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'b011111};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'b000111};

        rst = 1'b0;
        if_req = 0; mem_req = 0; mem_we = 0;
        flush_i = 0; stallreq_id = 0;
        if_addr = '0; mem_addr = '0;
        mem_wdata = '0; bus_rdata = '0;

        // Held in reset the arbiter stays idle, so stall_o is pure decode.
        for (int i = 0; i < 8; i++) begin
            cyc();
            mem_req     = tbl[i].mreq;
            if_req      = tbl[i].ireq;
            flush_i     = tbl[i].fl;
            stallreq_id = tbl[i].sid;
            #1;
            chk($sformatf("tbl%0d_stall", i), 32'(a_stall),
                32'(tbl[i].stall));
        end

        cyc();
        mem_req = 0; if_req = 0; flush_i = 0; stallreq_id = 0;
        chk("rst_ce", 32'(a_bus_ce), 0);
        chk("rst_we", 32'(a_bus_we), 0);
        chk("rst_acks", {30'd0, a_if_ack, a_mem_ack}, 0);
        chk("rst_addr", a_bus_addr, 0);
        chk("rst_rdata", a_if_rdata | a_mem_rdata, 0);
        rst = 1'b1;

        // Load with two wait states.
        cyc();
        mem_req = 1; mem_we = 0;
        mem_addr = 32'h40; bus_rdata = 32'hDEADBEEF;
        #1 chk("ld_stall_req", 32'(a_stall), 32'h1F);
        cyc();
        chk("ld_ce1", 32'(a_bus_ce), 1);
        chk("ld_we", 32'(a_bus_we), 0);
        chk("ld_addr", a_bus_addr, 32'h40);
        chk("ld_stall1", 32'(a_stall), 32'h1F);
        cyc();
        chk("ld_ce2", 32'(a_bus_ce), 1);
        chk("ld_noack", 32'(a_mem_ack), 0);
        cyc();
        chk("ld_ack", 32'(a_mem_ack), 1);
        chk("ld_rdata", a_mem_rdata, 32'hDEADBEEF);
        chk("ld_ce_off", 32'(a_bus_ce), 0);
        chk("ld_stall_ack", 32'(a_stall), 0);
        mem_req = 0;
        cyc();
        chk("ld_ack_pulse", 32'(a_mem_ack), 0);

        // Store and fetch together: store wins.
        cyc();
        mem_req = 1; mem_we = 1;
        mem_addr = 32'h80; mem_wdata = 32'h12345678;
        if_req = 1; if_addr = 32'h200;
        #1 chk("st_stall_both", 32'(a_stall), 32'h1F);
        cyc();
        chk("st_ce", 32'(a_bus_ce), 1);
        chk("st_we", 32'(a_bus_we), 1);
        chk("st_addr", a_bus_addr, 32'h80);
        chk("st_wdata", a_bus_wdata, 32'h12345678);
        cyc();
        chk("st_ce2", 32'(a_bus_ce), 1);
        cyc();
        chk("st_ack", 32'(a_mem_ack), 1);
        chk("st_no_capture", a_mem_rdata, 32'hDEADBEEF);
        chk("st_stall_ack", 32'(a_stall), 32'h03);
        chk("st_if_wait", 32'(a_if_ack), 0);
        mem_req = 0; mem_we = 0;
        cyc();
        chk("st_idle_ce", 32'(a_bus_ce), 0);
        cyc();
        chk("if2_ce", 32'(a_bus_ce), 1);
        chk("if2_we", 32'(a_bus_we), 0);
        chk("if2_addr", a_bus_addr, 32'h200);
        bus_rdata = 32'hCAFEF00D;
        cyc();
        chk("if2_noack", 32'(a_if_ack), 0);
        cyc();
        chk("if2_ack", 32'(a_if_ack), 1);
        chk("if2_rdata", a_if_rdata, 32'hCAFEF00D);
        chk("if2_stall_ack", 32'(a_stall), 0);
        if_req = 0;
        cyc();

        // Flush in the first fetch cycle aborts it.
        cyc();
        if_req = 1; if_addr = 32'h300;
        cyc();
        chk("fl_ce", 32'(a_bus_ce), 1);
        flush_i = 1;
        #1 chk("fl_stall", 32'(a_stall), 0);
        cyc();
        chk("fl_ce_drop", 32'(a_bus_ce), 0);
        chk("fl_noack", 32'(a_if_ack), 0);
        flush_i = 0; if_addr = 32'h100;
        bus_rdata = 32'h11112222;
        #1 chk("fl_stall_new", 32'(a_stall), 32'h03);
        cyc();
        chk("fl_new_ce", 32'(a_bus_ce), 1);
        chk("fl_new_addr", a_bus_addr, 32'h100);
        chk("fl_new_noack", 32'(a_if_ack), 0);
        cyc();
        chk("fl_new_ce2", 32'(a_bus_ce), 1);
        cyc();
        chk("fl_new_ack", 32'(a_if_ack), 1);
        chk("fl_new_rdata", a_if_rdata, 32'h11112222);
        if_req = 0;
        cyc();

        // Reset in the middle of a load.
        cyc();
        mem_req = 1; mem_we = 0;
        mem_addr = 32'h44; bus_rdata = 32'h55;
        cyc();
        chk("rs_ce", 32'(a_bus_ce), 1);
        rst = 0;
        cyc();
        chk("rs_ce_off", 32'(a_bus_ce), 0);
        chk("rs_noack", 32'(a_mem_ack), 0);
        chk("rs_addr", a_bus_addr, 0);
        chk("rs_wdata", a_bus_wdata, 0);
        chk("rs_mrdata", a_mem_rdata, 0);
        chk("rs_irdata", a_if_rdata, 0);
        rst = 1;
        cyc();
        chk("rs_regrant", 32'(a_bus_ce), 1);
        chk("rs_addr2", a_bus_addr, 32'h44);
        cyc();
        chk("rs_ce2", 32'(a_bus_ce), 1);
        chk("rs_noack2", 32'(a_mem_ack), 0);
        cyc();
        chk("rs_ack", 32'(a_mem_ack), 1);
        chk("rs_rdata", a_mem_rdata, 32'h55);
        mem_req = 0;

        // WAIT_CYCLES=1 instance: back-to-back fetches, 3 cycles apart.
        cyc();
        rst = 0;
        cyc();
        rst = 1;
        cyc();
        if_req = 1; if_addr = 32'h0; bus_rdata = 32'hA0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("b2b%0d_ce", k), 32'(b_bus_ce), 1);
            chk($sformatf("b2b%0d_addr", k), b_bus_addr, 32'(4 * k));
            chk($sformatf("b2b%0d_noack", k), 32'(b_if_ack), 0);
            cyc();
            chk($sformatf("b2b%0d_ack", k), 32'(b_if_ack), 1);
            chk($sformatf("b2b%0d_rdata", k), b_if_rdata,
                32'(32'hA0 + 4 * k));
            chk($sformatf("b2b%0d_ce_off", k), 32'(b_bus_ce), 0);
            if_addr   = 32'(4 * (k + 1));
            bus_rdata = 32'(32'hA0 + 4 * (k + 1));
            cyc();
            chk($sformatf("b2b%0d_idle_ack", k), 32'(b_if_ack), 0);
            chk($sformatf("b2b%0d_idle_ce", k), 32'(b_bus_ce), 0);
        end
        if_req = 0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
